// File: rtl/video_block_locator_if.sv
// Parallel video stream (sync, data enable, RGB pixel) between a pattern source and a sink.
interface video_block_locator_if #(
  parameter int unsigned COLOR_DEPTH = 8
) ();
  logic                       vs_in;
  logic                       hs_in;
  logic                       de_in;
  logic [3*COLOR_DEPTH-1:0]   pixel_in;

  modport master (output vs_in, output hs_in, output de_in, output pixel_in);
  modport slave  (input  vs_in, input  hs_in, input  de_in, input  pixel_in);
endinterface

// File: rtl/video_block_locator.sv
// Video sink analyzer: rebuilds active x/y from de, measures resolution and locates the
// bounding box / pixel count of a target colour, publishing results once per frame.
module video_block_locator #(
  parameter int unsigned                 COLOR_DEPTH = 8,
  parameter int unsigned                 X_BITS      = 12,
  parameter int unsigned                 Y_BITS      = 12,
  parameter logic [X_BITS-1:0]           H_ACT       = 12'd1280,
  parameter logic [Y_BITS-1:0]           V_ACT       = 12'd720,
  parameter logic [3*COLOR_DEPTH-1:0]    TARGET      = '0,
  parameter logic [3*COLOR_DEPTH-1:0]    MATCH_MASK  = '1,
  parameter logic                        VS_POL      = 1'b1
) (
  input  logic                      pix_clk,
  input  logic                      rstn,
  video_block_locator_if.slave      vid,
  output logic                      frame_valid,
  output logic [X_BITS-1:0]         h_act_meas,
  output logic [Y_BITS-1:0]         v_act_meas,
  output logic                      frame_err,
  output logic                      blk_found,
  output logic [X_BITS-1:0]         blk_x0,
  output logic [Y_BITS-1:0]         blk_y0,
  output logic [X_BITS-1:0]         blk_x1,
  output logic [Y_BITS-1:0]         blk_y1,
  output logic [X_BITS+Y_BITS-1:0]  blk_cnt
);

  localparam int unsigned CNT_W = X_BITS + Y_BITS;

  logic              vs_d, de_d;
  logic              vs_edge, de_fall, match;
  logic              hs_unused;
  logic [X_BITS-1:0] x_cnt, line_len, ref_len;
  logic [Y_BITS-1:0] y_cnt, pix_y;
  logic              len_err;
  logic [X_BITS-1:0] min_x, max_x, min_x_n, max_x_n;
  logic [Y_BITS-1:0] min_y, max_y, min_y_n, max_y_n;
  logic [CNT_W-1:0]  cnt, cnt_n;

  // hsync is observed on the bus but carries no information for this analyzer
  assign hs_unused = vid.hs_in;

  assign vs_edge = (vid.vs_in == VS_POL) && (vs_d != VS_POL);
  assign de_fall = de_d && !vid.de_in;
  assign match   = vid.de_in && (((vid.pixel_in ^ TARGET) & MATCH_MASK) == '0);
  // a pixel arriving with the frame edge is the first row of the new frame
  assign pix_y   = vs_edge ? '0 : y_cnt;

  // Edge-detect history and raster position counters
  always_ff @(posedge pix_clk or negedge rstn) begin
    if (!rstn) begin
      vs_d     <= 1'b0;
      de_d     <= 1'b0;
      x_cnt    <= '0;
      y_cnt    <= '0;
      line_len <= '0;
      ref_len  <= '0;
      len_err  <= 1'b0;
    end else begin
      vs_d <= vid.vs_in;
      de_d <= vid.de_in;
      if (de_fall) begin
        x_cnt    <= '0;
        line_len <= x_cnt;
      end else if (vid.de_in && (x_cnt != '1)) begin
        x_cnt <= x_cnt + X_BITS'(1);
      end
      if (vs_edge) begin
        y_cnt   <= '0;
        len_err <= 1'b0;
      end else if (de_fall) begin
        if (y_cnt != '1) y_cnt <= y_cnt + Y_BITS'(1);
        if (y_cnt == '0)            ref_len <= x_cnt;
        else if (ref_len != x_cnt)  len_err <= 1'b1;
      end
    end
  end

  // Bounding-box trackers restart on a frame edge, then absorb the current pixel
  always_comb begin
    min_x_n = vs_edge ? '1 : min_x;
    min_y_n = vs_edge ? '1 : min_y;
    max_x_n = vs_edge ? '0 : max_x;
    max_y_n = vs_edge ? '0 : max_y;
    cnt_n   = vs_edge ? '0 : cnt;
    if (match) begin
      if (x_cnt < min_x_n) min_x_n = x_cnt;
      if (pix_y < min_y_n) min_y_n = pix_y;
      if (x_cnt > max_x_n) max_x_n = x_cnt;
      if (pix_y > max_y_n) max_y_n = pix_y;
      if (cnt_n != '1)     cnt_n   = cnt_n + CNT_W'(1);
    end
  end

  always_ff @(posedge pix_clk or negedge rstn) begin
    if (!rstn) begin
      min_x <= '1;
      min_y <= '1;
      max_x <= '0;
      max_y <= '0;
      cnt   <= '0;
    end else begin
      min_x <= min_x_n;
      min_y <= min_y_n;
      max_x <= max_x_n;
      max_y <= max_y_n;
      cnt   <= cnt_n;
    end
  end

  // Publish the finished frame; results hold until the next completed frame
  always_ff @(posedge pix_clk or negedge rstn) begin
    if (!rstn) begin
      frame_valid <= 1'b0;
      h_act_meas  <= '0;
      v_act_meas  <= '0;
      frame_err   <= 1'b0;
      blk_found   <= 1'b0;
      blk_x0      <= '0;
      blk_y0      <= '0;
      blk_x1      <= '0;
      blk_y1      <= '0;
      blk_cnt     <= '0;
    end else begin
      frame_valid <= 1'b0;
      if (vs_edge && (y_cnt != '0)) begin
        frame_valid <= 1'b1;
        h_act_meas  <= line_len;
        v_act_meas  <= y_cnt;
        frame_err   <= len_err || (line_len != H_ACT) || (y_cnt != V_ACT);
        blk_found   <= (cnt != '0);
        blk_x0      <= (cnt != '0) ? min_x : '0;
        blk_y0      <= (cnt != '0) ? min_y : '0;
        blk_x1      <= (cnt != '0) ? max_x : '0;
        blk_y1      <= (cnt != '0) ? max_y : '0;
        blk_cnt     <= cnt;
      end
    end
  end

endmodule
